// File: rtl/pmp_csr_file.sv
// rtl/pmp_csr_file.sv - PMP configuration/address CSR storage with WARL and lock handling
//
// Ports:
//   clock, reset               single clock, synchronous active-high reset
//   io_csr_req/io_csr_ready    request handshake; ready is high only in IDLE
//   io_csr_we                  1 = write (returns pre-write value), 0 = read
//   io_csr_addr/io_csr_wdata   CSR address and write data
//   io_csr_prv                 privilege of the access; only M-mode (2'b11) is legal
//   io_csr_resp_valid          one-cycle response strobe, the cycle after acceptance
//   io_csr_rdata               pre-write value of the addressed CSR
//   io_csr_illegal             access faulted (bad privilege or unmapped address)
//   io_pmpcfg/io_pmpaddr       registered per-entry cfg/address to the PMP checker
module pmp_csr_file #(
    parameter int PMP_CNT   = 16,
    parameter int PMPADDR_W = 54,
    parameter int XLEN      = 64
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 io_csr_req,
    output logic                                 io_csr_ready,
    input  logic                                 io_csr_we,
    input  logic [11:0]                          io_csr_addr,
    input  logic [XLEN-1:0]                      io_csr_wdata,
    input  logic [1:0]                           io_csr_prv,
    output logic                                 io_csr_resp_valid,
    output logic [XLEN-1:0]                      io_csr_rdata,
    output logic                                 io_csr_illegal,
    output logic [PMP_CNT-1:0][7:0]              io_pmpcfg,
    output logic [PMP_CNT-1:0][PMPADDR_W-1:0]    io_pmpaddr
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    state_t                            state_q, state_d;
    logic [PMP_CNT-1:0][7:0]           cfg_q, cfg_d;
    logic [PMP_CNT-1:0][PMPADDR_W-1:0] addr_q, addr_d;
    logic [XLEN-1:0]                   rdata_q, rdata_d;
    logic                              illegal_q, illegal_d;

    logic            accept;
    logic            is_cfg0, is_cfg2, is_addr, legal;
    logic [XLEN-1:0] rd_value;
    logic [PMP_CNT-1:0] addr_locked;

    // Reserved bits read as zero; the reserved R=0/W=1 combination degrades to W=0.
    function automatic logic [7:0] warl_cfg(input logic [7:0] b);
        return {b[7], 2'b00, b[4:3], b[2], b[1] & b[0], b[0]};
    endfunction

    assign accept  = io_csr_req && (state_q == ST_IDLE);
    assign is_cfg0 = (io_csr_addr == 12'h3A0);
    assign is_cfg2 = (io_csr_addr == 12'h3A2);
    assign is_addr = (io_csr_addr[11:4] == 8'h3B);
    assign legal   = (io_csr_prv == 2'b11) && (is_cfg0 || is_cfg2 || is_addr);

    // An address is frozen by its own lock, or when the next entry is a locked
    // TOR region that uses it as its lower bound.
    always_comb begin
        for (int i = 0; i < PMP_CNT; i++) begin
            addr_locked[i] = cfg_q[i][7];
        end
        for (int i = 0; i < PMP_CNT - 1; i++) begin
            if (cfg_q[i+1][7] && (cfg_q[i+1][4:3] == 2'b01)) begin
                addr_locked[i] = 1'b1;
            end
        end
    end

    always_comb begin
        rd_value = '0;
        if (is_cfg0) begin
            rd_value = cfg_q[7:0];
        end else if (is_cfg2) begin
            rd_value = cfg_q[15:8];
        end else begin
            for (int i = 0; i < PMP_CNT; i++) begin
                if (io_csr_addr[3:0] == 4'(i)) begin
                    rd_value = {{(XLEN-PMPADDR_W){1'b0}}, addr_q[i]};
                end
            end
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cfg_q     <= '0;
            addr_q    <= '0;
            rdata_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cfg_q     <= cfg_d;
            addr_q    <= addr_d;
            rdata_q   <= rdata_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Register updates and response capture, all committed on the accept edge.
    // Lock decisions look only at cfg_q, so a byte setting L in this write does
    // not affect its neighbours until the next access.
    always_comb begin
        cfg_d     = cfg_q;
        addr_d    = addr_q;
        rdata_d   = rdata_q;
        illegal_d = illegal_q;
        if (accept) begin
            if (!legal) begin
                rdata_d   = '0;
                illegal_d = 1'b1;
            end else begin
                rdata_d   = rd_value;
                illegal_d = 1'b0;
                if (io_csr_we) begin
                    for (int e = 0; e < PMP_CNT; e++) begin
                        if (((e < 8) ? is_cfg0 : is_cfg2) && !cfg_q[e][7]) begin
                            cfg_d[e] = warl_cfg(io_csr_wdata[(e % 8) * 8 +: 8]);
                        end
                    end
                    for (int i = 0; i < PMP_CNT; i++) begin
                        if (is_addr && (io_csr_addr[3:0] == 4'(i)) && !addr_locked[i]) begin
                            addr_d[i] = io_csr_wdata[PMPADDR_W-1:0];
                        end
                    end
                end
            end
        end
    end

    // Output logic
    always_comb begin
        io_csr_ready      = (state_q == ST_IDLE);
        io_csr_resp_valid = (state_q == ST_RESP);
        io_csr_rdata      = rdata_q;
        io_csr_illegal    = illegal_q;
        io_pmpcfg         = cfg_q;
        io_pmpaddr        = addr_q;
    end

endmodule
